// File: rtl/lowrisc_eth_pkg.sv
// Shared types and constants for the Ethernet TX frame arbiter.
package lowrisc_eth_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned CNT_W  = 16;
    localparam int unsigned IDX_W  = 2;
    localparam logic [DATA_W-1:0] ABORT_DATA = 8'h00;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_XFER  = 2'd1,
        ST_DRAIN = 2'd2
    } arb_state_e;

    typedef struct packed {
        logic [DATA_W-1:0] tdata;
        logic              tlast;
        logic              tuser;
    } axis_beat_t;

    // Beat emitted in place of the rest of a frame whose source went silent.
    function automatic axis_beat_t abort_beat();
        axis_beat_t b;
        b.tdata = ABORT_DATA;
        b.tlast = 1'b1;
        b.tuser = 1'b1;
        return b;
    endfunction

endpackage

// File: rtl/lowrisc_eth_tx_arb_if.sv
// Per-source AXI-stream inputs and the merged AXI-stream output of the TX arbiter.
interface lowrisc_eth_tx_arb_if
    import lowrisc_eth_pkg::*;
#(
    parameter int unsigned PORTS = 2
);
    logic [DATA_W*PORTS-1:0] s_axis_tdata;
    logic [PORTS-1:0]        s_axis_tvalid;
    logic [PORTS-1:0]        s_axis_tlast;
    logic [PORTS-1:0]        s_axis_tuser;
    logic [PORTS-1:0]        s_axis_tready;

    logic [DATA_W-1:0]       m_axis_tdata;
    logic                    m_axis_tvalid;
    logic                    m_axis_tlast;
    logic                    m_axis_tuser;
    logic                    m_axis_tready;

    modport slave (
        input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, s_axis_tuser, m_axis_tready,
        output s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser
    );

    modport master (
        output s_axis_tdata, s_axis_tvalid, s_axis_tlast, s_axis_tuser, m_axis_tready,
        input  s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser
    );
endinterface

// File: rtl/lowrisc_rr_arb.sv
// Round-robin pick: lowest-index requester strictly after last_grant, wrapping.
module lowrisc_rr_arb
    import lowrisc_eth_pkg::*;
#(
    parameter int unsigned PORTS = 2
) (
    input  logic [PORTS-1:0] req,
    input  logic [IDX_W-1:0] last_grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_found
);
    logic             found_hi;
    logic             found_lo;
    logic [IDX_W-1:0] idx_hi;
    logic [IDX_W-1:0] idx_lo;

    // Descending scan so the lowest index in each half is the one left standing.
    always_comb begin
        found_hi = 1'b0;
        found_lo = 1'b0;
        idx_hi   = '0;
        idx_lo   = '0;
        for (int i = int'(PORTS) - 1; i >= 0; i--) begin
            if (req[i]) begin
                if (IDX_W'(i) > last_grant) begin
                    found_hi = 1'b1;
                    idx_hi   = IDX_W'(i);
                end else begin
                    found_lo = 1'b1;
                    idx_lo   = IDX_W'(i);
                end
            end
        end
        grant_found = found_hi || found_lo;
        grant_idx   = found_hi ? idx_hi : idx_lo;
    end
endmodule

// File: rtl/lowrisc_eth_tx_arb.sv
// Frame-atomic round-robin merge of byte-wide AXI-stream sources into one GMII TX stream.
module lowrisc_eth_tx_arb
    import lowrisc_eth_pkg::*;
#(
    parameter int unsigned PORTS         = 2,
    parameter int unsigned STALL_TIMEOUT = 16
) (
    input  logic                  clk,
    input  logic                  rstn,
    lowrisc_eth_tx_arb_if.slave   bus,
    output logic                  grant_valid,
    output logic [IDX_W-1:0]      grant_idx,
    output logic [CNT_W-1:0]      frame_count,
    output logic [CNT_W-1:0]      abort_count
);
    localparam int unsigned STALL_W = 8;

    arb_state_e        state;
    logic [IDX_W-1:0]  last_grant;
    logic [IDX_W-1:0]  grant;
    logic [STALL_W-1:0] stall_cnt;
    axis_beat_t        slice;
    logic              slice_valid;

    logic              accept_en_c;
    logic              sel_valid_c;
    axis_beat_t        sel_beat_c;
    logic [PORTS-1:0]  ready_c;
    logic [IDX_W-1:0]  rr_idx;
    logic              rr_found;

    lowrisc_rr_arb #(.PORTS(PORTS)) u_rr (
        .req         (bus.s_axis_tvalid),
        .last_grant  (last_grant),
        .grant_idx   (rr_idx),
        .grant_found (rr_found)
    );

    assign accept_en_c = !slice_valid || bus.m_axis_tready;

    // Mux the granted lane and steer tready back to it only.
    always_comb begin
        sel_valid_c = 1'b0;
        sel_beat_c  = '0;
        ready_c     = '0;
        for (int i = 0; i < int'(PORTS); i++) begin
            if (IDX_W'(i) == grant) begin
                sel_valid_c      = bus.s_axis_tvalid[i];
                sel_beat_c.tdata = bus.s_axis_tdata[DATA_W*i +: DATA_W];
                sel_beat_c.tlast = bus.s_axis_tlast[i];
                sel_beat_c.tuser = bus.s_axis_tuser[i];
                if (state == ST_XFER) begin
                    ready_c[i] = accept_en_c;
                end else if (state == ST_DRAIN) begin
                    ready_c[i] = 1'b1;
                end
            end
        end
    end

    assign bus.s_axis_tready = ready_c;
    assign bus.m_axis_tvalid = slice_valid;
    assign bus.m_axis_tdata  = slice.tdata;
    assign bus.m_axis_tlast  = slice.tlast;
    assign bus.m_axis_tuser  = slice.tuser;
    assign grant_idx         = grant;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state       <= ST_IDLE;
            last_grant  <= IDX_W'(PORTS - 1);
            grant       <= '0;
            grant_valid <= 1'b0;
            stall_cnt   <= '0;
            slice       <= '0;
            slice_valid <= 1'b0;
            frame_count <= '0;
            abort_count <= '0;
        end else begin
            if (slice_valid && bus.m_axis_tready) begin
                slice_valid <= 1'b0;
            end
            unique case (state)
                ST_IDLE: begin
                    if (rr_found) begin
                        grant       <= rr_idx;
                        grant_valid <= 1'b1;
                        stall_cnt   <= '0;
                        state       <= ST_XFER;
                    end
                end
                ST_XFER: begin
                    // A valid beat always wins over the timeout on the same cycle.
                    if (accept_en_c) begin
                        if (sel_valid_c) begin
                            slice       <= sel_beat_c;
                            slice_valid <= 1'b1;
                            stall_cnt   <= '0;
                            if (sel_beat_c.tlast) begin
                                frame_count <= frame_count + 1'b1;
                                last_grant  <= grant;
                                grant_valid <= 1'b0;
                                state       <= ST_IDLE;
                            end
                        end else if (stall_cnt == STALL_W'(STALL_TIMEOUT - 1)) begin
                            slice       <= abort_beat();
                            slice_valid <= 1'b1;
                            abort_count <= abort_count + 1'b1;
                            stall_cnt   <= '0;
                            state       <= ST_DRAIN;
                        end else begin
                            stall_cnt <= stall_cnt + 1'b1;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (sel_valid_c && sel_beat_c.tlast) begin
                        last_grant  <= grant;
                        grant_valid <= 1'b0;
                        state       <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: doc/lowrisc_eth_tx_arb.md
LOWRISC_ETH_TX_ARB -- requirements
Module: lowrisc_eth_tx_arb

Interface
REQ-001 Parameter PORTS, default 2, number of byte-wide AXI-stream frame sources; SHALL be in range 2..4.
REQ-002 Parameter STALL_TIMEOUT, default 16, idle cycles mid-frame before the granted frame is aborted; SHALL be in range 2..255.
REQ-003 Port clk  in  1  single clock; all logic SHALL be clocked on its rising edge.
REQ-004 Port rstn  in  1  reset; SHALL be synchronous and active-low.
REQ-005 Ports s_axis_tdata  in  8*PORTS, s_axis_tvalid/tlast/tuser  in  PORTS, s_axis_tready  out  PORTS: per-source frame inputs, port i on byte lane i.
REQ-006 Ports m_axis_tdata  out  8, m_axis_tvalid/tlast/tuser  out  1, m_axis_tready  in  1: merged stream feeding the GMII transmitter input.
REQ-007 Ports grant_valid  out  1, grant_idx  out  2: current owner of the output.
REQ-008 Ports frame_count  out  16, abort_count  out  16: frames completed and frames aborted; both wrap modulo 2^16.

Function
REQ-009 Arbitration SHALL be frame-atomic: once granted, a port keeps the output until its tlast beat is accepted or the frame is aborted.
REQ-010 Round-robin: from IDLE, grant the lowest-index valid port strictly after last_grant, wrapping; last_grant resets to PORTS-1, so port 0 wins first.
REQ-011 States: IDLE, XFER, DRAIN; IDLE->XFER one cycle after any s_axis_tvalid is high; grant_valid=1 exactly in XFER and DRAIN.
REQ-012 Output stage: one register slice; accept-enable = !m_axis_tvalid || m_axis_tready; accepted beats appear on m_axis one cycle later; full throughput of one beat per cycle SHALL be sustained.
REQ-013 In XFER: s_axis_tready[grant] = accept-enable; all other s_axis_tready = 0; tdata/tlast/tuser SHALL be copied unmodified.
REQ-014 Accepted granted beat with tlast=1: frame_count+1, last_grant=grant, next state IDLE; tuser is passed through and not counted as an abort.
REQ-015 Stall counter: in XFER, increments each cycle the granted tvalid=0 and accept-enable=1; clears on any accepted beat and on entry to XFER.
REQ-016 Counter reaching STALL_TIMEOUT: load output slice with abort beat (tdata 8'h00, tlast 1, tuser 1), abort_count+1, go to DRAIN.
REQ-017 DRAIN: s_axis_tready[grant]=1, beats discarded; when a beat with tlast=1 is accepted, last_grant=grant, go to IDLE.
REQ-018 A port whose tlast coincides with its timeout cycle (tvalid high) SHALL complete normally; tvalid high always has priority over the timeout.
REQ-019 m_axis_tvalid SHALL never drop while m_axis_tready=0 (AXI hold rule); m_axis_tdata/tlast/tuser stable while stalled.
REQ-020 Simultaneous requests from all ports with back-to-back frames SHALL yield strict rotation 0,1,..,PORTS-1,0.
REQ-021 No beat SHALL be accepted in IDLE; the IDLE cycle between frames is the fixed arbitration bubble.

Reset
REQ-022 While rstn=0 at a clock edge: state=IDLE, last_grant=PORTS-1, stall counter=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tuser=0, m_axis_tdata=0, s_axis_tready=0, grant_valid=0, grant_idx=0, frame_count=0, abort_count=0.
REQ-023 Reset asserted mid-frame SHALL discard the output slice contents without emitting tlast; recovery of the partial frame is upstream's responsibility.

Structure
REQ-024 State encoding, abort-beat constant (8'h00) and counter width (16) SHALL live in shared package lowrisc_eth_pkg.
REQ-025 Round-robin selection SHALL be one combinational sub-module lowrisc_rr_arb (request vector, last_grant in; grant_idx, grant_found out).
REQ-026 Target size: 150-300 lines RTL total.

Verification
REQ-027 Port 0 sends a 60-byte frame, m_axis_tready=1 -> 60 beats on m_axis in order, tlast on beat 60, frame_count=1, grant_idx=0.
REQ-028 Ports 0 and 1 each hold 3 back-to-back frames -> output grant order 0,1,0,1,0,1, one-cycle bubble between frames, frame_count=6.
REQ-029 Port 1 stalls after 10 bytes, STALL_TIMEOUT=16 -> beat 11 is 8'h00 with tlast=1 and tuser=1 after 16 stalled cycles, abort_count=1; port 1's remaining 5 bytes are drained, then port 0 is granted.
REQ-030 m_axis_tready toggles 1,0,1,0 during a 20-byte frame -> all 20 bytes delivered, no duplicates or losses, no timeout increments while the source is valid.
REQ-031 rstn=0 for one cycle at byte 7 of a frame -> next cycle m_axis_tvalid=0, grant_valid=0, counters=0; the next request from port 0 is granted first.
REQ-032 Port 0 frame with tuser=1 on the tlast beat -> passed through unchanged, frame_count+1, abort_count unchanged.
